// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults and frame-slot constants for the I2S transmitter
package i2s_pkg;

    localparam int SAMPLE_W_DEF   = 16;
    localparam int CLK_HALF_DEF   = 10;
    localparam int FRAME_BITS_DEF = 50;
    localparam int HALF_DEF       = FRAME_BITS_DEF / 2;
    localparam int FIRST_SLOT     = 1;
    localparam int LAST_SLOT_DEF  = FIRST_SLOT + SAMPLE_W_DEF - 1;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic int half_of(input int frame_bits);
        return frame_bits / 2;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider, fall-event strobe and frame bit counter
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_HALF   = CLK_HALF_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic                          i_clk48,
    input  logic                          i_rst48,
    output logic                          o_bclk,
    output logic                          o_fall,
    output logic                          o_load,
    output logic [$clog2(FRAME_BITS)-1:0] o_bit_nxt
);
    localparam int DW = $clog2(CLK_HALF + 1);
    localparam int BW = $clog2(FRAME_BITS);

    logic [DW-1:0] r_div;
    logic [BW-1:0] r_bit;
    logic          r_bclk;
    logic          w_div_end;
    logic          w_bit_end;

    assign w_div_end = (r_div == DW'(CLK_HALF - 1));
    assign w_bit_end = (r_bit == BW'(FRAME_BITS - 1));

    // Strobe is high in the cycle whose closing edge drives BCLK low.
    assign o_fall    = w_div_end & r_bclk;
    assign o_load    = o_fall & w_bit_end;
    assign o_bit_nxt = w_bit_end ? '0 : r_bit + 1'b1;
    assign o_bclk    = r_bclk;

    always_ff @(posedge i_clk48 or posedge i_rst48) begin
        if (i_rst48) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
            r_bit  <= BW'(FRAME_BITS - 1);
        end else begin
            r_div <= w_div_end ? '0 : r_div + 1'b1;
            if (w_div_end) begin
                r_bclk <= ~r_bclk;
            end
            if (o_fall) begin
                r_bit <= o_bit_nxt;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - sample capture, double buffer and stereo I2S serialiser
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_HALF   = CLK_HALF_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
    input  logic                i_clk48,
    input  logic                i_rst48,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_pulse,
    input  logic                i_mute,
    output logic                o_bclk,
    output logic                o_lrclk,
    output logic                o_sdata,
    output logic                o_frame,
    output logic                o_underrun,
    output logic                o_overrun
);
    localparam int H         = half_of(FRAME_BITS);
    localparam int LAST_SLOT = FIRST_SLOT + SAMPLE_W - 1;
    localparam int BW        = $clog2(FRAME_BITS);
    localparam int SW        = $clog2(H);

    logic                w_fall;
    logic                w_load;
    logic [BW-1:0]       w_bit_nxt;
    logic                w_right;
    logic [SW-1:0]       w_slot;
    logic [SAMPLE_W-1:0] w_rev;
    logic [H-1:0]        w_slot_bits;
    logic [SAMPLE_W-1:0] w_load_word;

    logic [SAMPLE_W-1:0] r_pending;
    logic [SAMPLE_W-1:0] r_hold;
    logic                r_pend_valid;
    logic                r_lrclk;
    logic                r_sdata;
    logic                r_frame;
    logic                r_underrun;
    logic                r_overrun;

    i2s_bclk_gen #(
        .CLK_HALF   (CLK_HALF),
        .FRAME_BITS (FRAME_BITS)
    ) u_bclk_gen (
        .i_clk48   (i_clk48),
        .i_rst48   (i_rst48),
        .o_bclk    (o_bclk),
        .o_fall    (w_fall),
        .o_load    (w_load),
        .o_bit_nxt (w_bit_nxt)
    );

    assign w_right = (w_bit_nxt >= BW'(H));
    assign w_slot  = w_right ? SW'(w_bit_nxt - BW'(H)) : SW'(w_bit_nxt);

    // Slot s of either half carries hold[SAMPLE_W-s]; slot 0 is the I2S delay bit.
    for (genvar g = 0; g < SAMPLE_W; g++) begin : g_rev
        assign w_rev[g] = r_hold[SAMPLE_W-1-g];
    end

    always_comb begin
        w_slot_bits                       = '0;
        w_slot_bits[LAST_SLOT:FIRST_SLOT] = w_rev;
    end

    assign w_load_word = i_pulse      ? i_sample  :
                         r_pend_valid ? r_pending : r_hold;

    always_ff @(posedge i_clk48 or posedge i_rst48) begin
        if (i_rst48) begin
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_hold       <= '0;
            r_lrclk      <= 1'b0;
            r_sdata      <= 1'b0;
            r_frame      <= 1'b0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame    <= w_load;
            r_underrun <= w_load & ~i_pulse & ~r_pend_valid;
            r_overrun  <= i_pulse & r_pend_valid & ~w_load;

            if (i_pulse) begin
                r_pending <= i_sample;
            end
            if (w_load) begin
                r_hold       <= i_mute ? '0 : w_load_word;
                r_pend_valid <= 1'b0;
            end else if (i_pulse) begin
                r_pend_valid <= 1'b1;
            end

            if (w_fall) begin
                r_lrclk <= w_right ? CH_RIGHT : CH_LEFT;
                r_sdata <= w_slot_bits[w_slot];
            end
        end
    end

    assign o_lrclk    = r_lrclk;
    assign o_sdata    = r_sdata;
    assign o_frame    = r_frame;
    assign o_underrun = r_underrun;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - self-checking bench for i2s_tx against a frame-level reference model
module tb_i2s_tx;

    logic        clk;
    logic        rst;
    logic [15:0] sample;
    logic        pulse;
    logic        mute;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame;
    logic        underrun;
    logic        overrun;

    int          t;
    int          passed;
    int          total;
    int          phase;
    logic [15:0] q[$];
    logic [15:0] cur_word;

    i2s_tx dut (
        .i_clk48    (clk),
        .i_rst48    (rst),
        .i_sample   (sample),
        .i_pulse    (pulse),
        .i_mute     (mute),
        .o_bclk     (bclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_frame    (frame),
        .o_underrun (underrun),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int load_t(input int k);
        return 20 + 1000 * k;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s t=%0d: observed %b expected %b", tag, t, obs, exp);
    endtask

    task automatic model_reset();
        t = 0;
        q.delete();
        cur_word = 16'h0000;
    endtask

    // One clock edge: drive inputs, advance the model, check all outputs mid-cycle.
    task automatic cycle(input logic p, input logic [15:0] s, input logic m);
        logic        is_load;
        logic        e_ovr;
        logic        e_und;
        logic        e_lr;
        logic        e_sd;
        logic [15:0] tmp;
        int          b;
        int          sl;
        pulse  = p;
        sample = s;
        mute   = m;
        @(posedge clk);
        t++;
        is_load = (t >= 20) && (((t - 20) % 1000) == 0);
        e_ovr   = p && (q.size() > 0) && !is_load;
        e_und   = 1'b0;
        if (is_load) begin
            e_und = !p && (q.size() == 0);
            if (p) cur_word = s;
            else if (q.size() > 0) cur_word = q[$];
            if (m) cur_word = 16'h0000;
            q.delete();
        end else if (p) begin
            q.push_back(s);
        end
        e_lr = 1'b0;
        e_sd = 1'b0;
        if (t >= 20) begin
            b    = ((t - 20) / 20) % 50;
            e_lr = (b >= 25);
            sl   = b % 25;
            if (sl >= 1 && sl <= 16) begin
                tmp  = cur_word >> (16 - sl);
                e_sd = tmp[0];
            end
        end
        @(negedge clk);
        chk("bclk", bclk, ((t / 10) % 2) == 1);
        chk("lrclk", lrclk, e_lr);
        chk("sdata", sdata, e_sd);
        chk("frame", frame, is_load);
        chk("underrun", underrun, e_und);
        chk("overrun", overrun, e_ovr);
        pulse = 1'b0;
        mute  = 1'b0;
    endtask

    task automatic run_to(input int tend);
        while (t < tend) cycle(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        pulse  = 1'b0;
        mute   = 1'b0;
        sample = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bclk", bclk, 1'b0);
        chk("rst_lrclk", lrclk, 1'b0);
        chk("rst_sdata", sdata, 1'b0);
        chk("rst_frame", frame, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;

        // Idle first frame, then one sample ahead of the second load.
        run_to(1010);
        cycle(1'b1, 16'hA5C3, 1'b0);
        run_to(load_t(2));

        // Generator-rate strobes at a random phase against the frame.
        phase = int'($urandom_range(999, 0));
        for (int k = 2; k < 22; k++) begin
            run_to(load_t(k) + phase);
            cycle(1'b1, 16'($urandom), 1'b0);
        end
        run_to(load_t(22));

        // Two strobes inside one frame: second overwrites the first.
        run_to(load_t(22) + 99);
        cycle(1'b1, 16'h1234, 1'b0);
        run_to(load_t(22) + 299);
        cycle(1'b1, 16'h7FFF, 1'b0);

        // Strobe coincident with the load takes the bypass.
        run_to(load_t(24) - 1);
        cycle(1'b1, 16'h8001, 1'b0);

        // Pending full-scale word loaded while muted.
        run_to(load_t(24) + 499);
        cycle(1'b1, 16'hFFFF, 1'b0);
        run_to(load_t(25) - 1);
        cycle(1'b0, 16'h0000, 1'b1);

        // Asynchronous reset in the middle of the right half.
        run_to(load_t(25) + 605);
        chk("pre_rst_lrclk", lrclk, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bclk", bclk, 1'b0);
        chk("arst_lrclk", lrclk, 1'b0);
        chk("arst_sdata", sdata, 1'b0);
        chk("arst_frame", frame, 1'b0);
        chk("arst_underrun", underrun, 1'b0);
        chk("arst_overrun", overrun, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_to(1100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
